// File: rtl/tl_bus_arbiter.sv
// Two-requester TL-UL arbiter: one shared A/D channel pair, one transaction in flight.
// Tie-break policy: round-robin when TL_ARB_ROUND_ROBIN_EN is defined, else port 1 wins.
module tl_bus_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i_0,
  input  logic [2:0]        req_opcode_i_0,
  input  logic [ADDR_W-1:0] req_address_i_0,
  input  logic [DATA_W-1:0] req_data_i_0,
  input  logic              req_valid_i_1,
  input  logic [2:0]        req_opcode_i_1,
  input  logic [ADDR_W-1:0] req_address_i_1,
  input  logic [DATA_W-1:0] req_data_i_1,
  output logic              req_ready_o_0,
  output logic              req_ready_o_1,
  output logic              resp_valid_o_0,
  output logic [DATA_W-1:0] resp_data_o_0,
  output logic              resp_err_o_0,
  output logic              resp_valid_o_1,
  output logic [DATA_W-1:0] resp_data_o_1,
  output logic              resp_err_o_1,
  output logic              a_valid_o,
  output logic [2:0]        a_opcode_o,
  output logic [ADDR_W-1:0] a_address_o,
  output logic [DATA_W-1:0] a_data_o,
  input  logic              a_ready_i,
  input  logic              d_valid_i,
  input  logic [2:0]        d_opcode_i,
  input  logic [DATA_W-1:0] d_data_i,
  output logic              d_ready_o,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; a source holds valid and its payload stable until that edge.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q;
  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                any_req, resp_busy, grant_en, grant_1;
  logic                d_fire, d_err;

  assign any_req   = req_valid_i_0 | req_valid_i_1;
  // No grant in the response cycle, so a new request never overlaps a response.
  assign resp_busy = resp_valid_o_0 | resp_valid_o_1;
  assign grant_en  = (state_q == IDLE) & any_req & ~resp_busy & ~reset;
  assign d_fire    = (state_q == WAIT) & d_valid_i;
  assign d_err     = (d_opcode_i != 3'b000) & (d_opcode_i != 3'b001);

`ifdef TL_ARB_ROUND_ROBIN_EN
  logic prio_1_q;  // set when port 1 should win the next tie

  assign grant_1 = req_valid_i_1 & (~req_valid_i_0 | prio_1_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_1_q <= 1'b0;
    end else if (grant_en) begin
      prio_1_q <= ~grant_1;
    end
  end
`else
  assign grant_1 = req_valid_i_1;
`endif

  always_comb begin
    state_d       = state_q;
    req_ready_o_0 = 1'b0;
    req_ready_o_1 = 1'b0;
    a_valid_o     = 1'b0;
    d_ready_o     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_en) begin
          req_ready_o_1 = grant_1;
          req_ready_o_0 = ~grant_1;
          state_d       = SEND;
        end
      end
      SEND: begin
        a_valid_o = 1'b1;
        if (a_ready_i) state_d = WAIT;
      end
      WAIT: begin
        d_ready_o = 1'b1;
        if (d_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      owner_q        <= 1'b0;
      op_q           <= '0;
      addr_q         <= '0;
      data_q         <= '0;
      resp_valid_o_0 <= 1'b0;
      resp_valid_o_1 <= 1'b0;
      resp_err_o_0   <= 1'b0;
      resp_err_o_1   <= 1'b0;
      resp_data_o_0  <= '0;
      resp_data_o_1  <= '0;
    end else begin
      state_q <= state_d;
      if (grant_en) begin
        owner_q <= grant_1;
        op_q    <= grant_1 ? req_opcode_i_1  : req_opcode_i_0;
        addr_q  <= grant_1 ? req_address_i_1 : req_address_i_0;
        data_q  <= grant_1 ? req_data_i_1    : req_data_i_0;
      end
      resp_valid_o_0 <= d_fire & ~owner_q;
      resp_valid_o_1 <= d_fire & owner_q;
      resp_err_o_0   <= d_fire & ~owner_q & d_err;
      resp_err_o_1   <= d_fire & owner_q & d_err;
      if (d_fire & ~owner_q) resp_data_o_0 <= d_data_i;
      if (d_fire & owner_q)  resp_data_o_1 <= d_data_i;
    end
  end

  assign a_opcode_o  = op_q;
  assign a_address_o = addr_q;
  assign a_data_o    = data_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_tl_bus_arbiter.sv
// Directed bench for tl_bus_arbiter; tie-break expectations follow TL_ARB_ROUND_ROBIN_EN.
module tb_tl_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid_i_0 = 1'b0, req_valid_i_1 = 1'b0;
  logic [2:0]  req_opcode_i_0 = '0, req_opcode_i_1 = '0;
  logic [11:0] req_address_i_0 = '0, req_address_i_1 = '0;
  logic [31:0] req_data_i_0 = '0, req_data_i_1 = '0;
  logic        req_ready_o_0, req_ready_o_1;
  logic        resp_valid_o_0, resp_valid_o_1, resp_err_o_0, resp_err_o_1;
  logic [31:0] resp_data_o_0, resp_data_o_1;
  logic        a_valid_o, a_ready_i = 1'b0;
  logic [2:0]  a_opcode_o;
  logic [11:0] a_address_o;
  logic [31:0] a_data_o;
  logic        d_valid_i = 1'b0, d_ready_o;
  logic [2:0]  d_opcode_i = '0;
  logic [31:0] d_data_i = '0;
  logic [1:0]  dbg_state;

  logic [31:0] exp_q[$];
  int          n_vec = 0;
  int          n_miss = 0;
  int          ord[3];

  tl_bus_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i_0(req_valid_i_0), .req_opcode_i_0(req_opcode_i_0),
    .req_address_i_0(req_address_i_0), .req_data_i_0(req_data_i_0),
    .req_valid_i_1(req_valid_i_1), .req_opcode_i_1(req_opcode_i_1),
    .req_address_i_1(req_address_i_1), .req_data_i_1(req_data_i_1),
    .req_ready_o_0(req_ready_o_0), .req_ready_o_1(req_ready_o_1),
    .resp_valid_o_0(resp_valid_o_0), .resp_data_o_0(resp_data_o_0), .resp_err_o_0(resp_err_o_0),
    .resp_valid_o_1(resp_valid_o_1), .resp_data_o_1(resp_data_o_1), .resp_err_o_1(resp_err_o_1),
    .a_valid_o(a_valid_o), .a_opcode_o(a_opcode_o), .a_address_o(a_address_o),
    .a_data_o(a_data_o), .a_ready_i(a_ready_i),
    .d_valid_i(d_valid_i), .d_opcode_i(d_opcode_i), .d_data_i(d_data_i),
    .d_ready_o(d_ready_o), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One transaction from the current cycle (accept cycle N) to the cycle after the response.
  task automatic run_txn(input int p, input int a_delay, input logic [2:0] d_op,
                         input logic [31:0] d_dat, input logic exp_err);
    logic [2:0]  e_op;
    logic [11:0] e_addr;
    logic [31:0] e_data, exp_dat;
    @(negedge clk);
    check_eq("grant_p0", 32'(req_ready_o_0), 32'(p == 0));
    check_eq("grant_p1", 32'(req_ready_o_1), 32'(p == 1));
    check_eq("a_valid_at_accept", 32'(a_valid_o), 32'd0);
    check_eq("resp_one_cycle", 32'({resp_valid_o_1, resp_valid_o_0}), 32'd0);
    e_op   = (p == 1) ? req_opcode_i_1  : req_opcode_i_0;
    e_addr = (p == 1) ? req_address_i_1 : req_address_i_0;
    e_data = (p == 1) ? req_data_i_1    : req_data_i_0;
    @(posedge clk); #1;
    if (p == 1) req_valid_i_1 = 1'b0; else req_valid_i_0 = 1'b0;
    for (int i = 0; i <= a_delay; i++) begin
      a_ready_i = (i == a_delay);
      @(negedge clk);
      check_eq("a_valid_send", 32'(a_valid_o), 32'd1);
      check_eq("a_opcode", 32'(a_opcode_o), 32'(e_op));
      check_eq("a_address", 32'(a_address_o), 32'(e_addr));
      check_eq("a_data", a_data_o, e_data);
      check_eq("ready_low_send", 32'({req_ready_o_1, req_ready_o_0}), 32'd0);
      check_eq("d_ready_send", 32'(d_ready_o), 32'd0);
      @(posedge clk); #1;
    end
    a_ready_i  = 1'b0;
    d_valid_i  = 1'b1;
    d_opcode_i = d_op;
    d_data_i   = d_dat;
    exp_q.push_back(d_dat);
    @(negedge clk);
    check_eq("d_ready_wait", 32'(d_ready_o), 32'd1);
    check_eq("single_handshake", 32'(a_valid_o), 32'd0);
    check_eq("state_wait", 32'(dbg_state), 32'd2);
    @(posedge clk); #1;
    d_valid_i = 1'b0;
    @(negedge clk);
    exp_dat = exp_q.pop_front();
    check_eq("resp_valid_owner", 32'(p == 1 ? resp_valid_o_1 : resp_valid_o_0), 32'd1);
    check_eq("resp_valid_other", 32'(p == 1 ? resp_valid_o_0 : resp_valid_o_1), 32'd0);
    check_eq("resp_err", 32'(p == 1 ? resp_err_o_1 : resp_err_o_0), 32'(exp_err));
    check_eq("resp_data", (p == 1) ? resp_data_o_1 : resp_data_o_0, exp_dat);
    check_eq("no_bypass", 32'({req_ready_o_1, req_ready_o_0}), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    // reset state, with a request already pending
    req_valid_i_0 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", 32'({req_ready_o_1, req_ready_o_0}), 32'd0);
    check_eq("rst_a_valid", 32'(a_valid_o), 32'd0);
    check_eq("rst_d_ready", 32'(d_ready_o), 32'd0);
    check_eq("rst_resp", 32'({resp_valid_o_1, resp_valid_o_0, resp_err_o_1, resp_err_o_0}), 32'd0);
    check_eq("rst_resp_data0", resp_data_o_0, 32'd0);
    check_eq("rst_resp_data1", resp_data_o_1, 32'd0);
    check_eq("rst_a_address", 32'(a_address_o), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);

    // single fetch, accepted the first cycle after reset
    @(posedge clk); #1;
    reset = 1'b0;
    req_opcode_i_0 = 3'b100; req_address_i_0 = 12'h004; req_data_i_0 = 32'h0;
    run_txn(0, 0, 3'b001, 32'h0000_0013, 1'b0);

    // error response on the data port
    req_valid_i_1 = 1'b1; req_opcode_i_1 = 3'b000;
    req_address_i_1 = 12'h100; req_data_i_1 = 32'hDEAD_BEEF;
    run_txn(1, 0, 3'b010, 32'hBAD0_BAD0, 1'b1);

    // A-channel backpressure for 5 cycles
    req_valid_i_1 = 1'b1; req_opcode_i_1 = 3'b100;
    req_address_i_1 = 12'h7FC; req_data_i_1 = 32'h0;
    run_txn(1, 5, 3'b000, 32'h1111_2222, 1'b0);
    @(negedge clk);
    check_eq("held_resp_data0", resp_data_o_0, 32'h0000_0013);
    check_eq("held_resp_data1", resp_data_o_1, 32'h1111_2222);
    check_eq("held_resp_err1", 32'(resp_err_o_1), 32'd0);
    @(posedge clk); #1;

    // contention straight after reset, both requesters re-request after service
`ifdef TL_ARB_ROUND_ROBIN_EN
    ord[0] = 0; ord[1] = 1; ord[2] = 0;
`else
    ord[0] = 1; ord[1] = 1; ord[2] = 1;
`endif
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    req_opcode_i_0 = 3'b100; req_address_i_0 = 12'h010; req_data_i_0 = 32'h0;
    req_opcode_i_1 = 3'b000; req_address_i_1 = 12'h020; req_data_i_1 = 32'hCAFE_0001;
    req_valid_i_0 = 1'b1; req_valid_i_1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run_txn(ord[k], 0, 3'b001, 32'h0000_00A0 + 32'(k), 1'b0);
      if (ord[k] == 1) req_valid_i_1 = 1'b1; else req_valid_i_0 = 1'b1;
    end
    req_valid_i_0 = 1'b0; req_valid_i_1 = 1'b0;

    // reset while waiting on D, then a stale D beat
    req_valid_i_0 = 1'b1; req_opcode_i_0 = 3'b000;
    req_address_i_0 = 12'h0AA; req_data_i_0 = 32'h0000_0055;
    @(negedge clk);
    check_eq("rw_grant", 32'(req_ready_o_0), 32'd1);
    @(posedge clk); #1;
    req_valid_i_0 = 1'b0; a_ready_i = 1'b1;
    @(negedge clk);
    check_eq("rw_a_valid", 32'(a_valid_o), 32'd1);
    @(posedge clk); #1;
    a_ready_i = 1'b0;
    @(negedge clk);
    check_eq("rw_in_wait", 32'(d_ready_o), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    d_valid_i = 1'b1; d_opcode_i = 3'b001; d_data_i = 32'hFFFF_0000;
    @(negedge clk);
    check_eq("stale_d_ready", 32'(d_ready_o), 32'd0);
    check_eq("stale_a_valid", 32'(a_valid_o), 32'd0);
    @(posedge clk); #1;
    d_valid_i = 1'b0;
    @(negedge clk);
    check_eq("stale_no_resp", 32'({resp_valid_o_1, resp_valid_o_0}), 32'd0);
    check_eq("stale_resp_data0", resp_data_o_0, 32'd0);
    @(posedge clk); #1;
    req_valid_i_0 = 1'b1; req_opcode_i_0 = 3'b100;
    req_address_i_0 = 12'h008; req_data_i_0 = 32'h0;
    run_txn(0, 0, 3'b001, 32'h0000_0093, 1'b0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/tl_bus_arbiter.md
TL_BUS_ARBITER -- requirements
Module: tl_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, the request address width.
REQ-002 SHALL have parameter DATA_W, default 32, the request and response data width.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have, per requester port p (p=0 instruction fetch, p=1 data access), these inputs: req_valid_i_p (1), req_opcode_i_p (3), req_address_i_p (ADDR_W), req_data_i_p (DATA_W).
REQ-006 SHALL have, per requester port p, output req_ready_o_p (1), the request-accepted strobe.
REQ-007 SHALL have, per requester port p, these outputs: resp_valid_o_p (1), resp_data_o_p (DATA_W), resp_err_o_p (1).
REQ-008 SHALL have these channel-A outputs: a_valid_o (1), a_opcode_o (3), a_address_o (ADDR_W), a_data_o (DATA_W).
REQ-009 SHALL have channel-A input a_ready_i (1).
REQ-010 SHALL have these channel-D inputs: d_valid_i (1), d_opcode_i (3), d_data_i (DATA_W).
REQ-011 SHALL have channel-D output d_ready_o (1).

Function
REQ-012 SHALL share one TL-UL A/D channel pair between the two requesters, with at most one transaction outstanding.
REQ-013 SHALL implement a state machine with states IDLE, SEND and WAIT.
REQ-014 In IDLE with >=1 req_valid_i_p high, SHALL select one winner, assert req_ready_o of the winner only, in the same cycle (combinational), latch the winner's opcode/address/data and owner id, and go to SEND.
REQ-015 SHALL keep req_ready_o of both ports low in SEND and WAIT; a requester holds req_valid_i until its req_ready_o is seen.
REQ-016 In SEND, SHALL drive a_valid_o=1 with the latched fields, which stay stable until a_valid_o && a_ready_i, then go to WAIT.
REQ-017 In WAIT, SHALL drive d_ready_o=1; on d_valid_i it SHALL register d_data_i into resp_data_o of the owner, pulse that owner's resp_valid_o for exactly one cycle on the next cycle, and go to IDLE.
REQ-018 SHALL set resp_err_o of the owner, coincident with resp_valid_o, when d_opcode_i is neither 3'b000 (AccessAck) nor 3'b001 (AccessAckData); otherwise resp_err_o=0.
REQ-019 SHALL hold a_valid_o=0 in IDLE and WAIT.
REQ-020 SHALL hold d_ready_o=0 in IDLE and SEND; d_valid_i in those states SHALL be ignored.
REQ-021 SHALL pass the request opcode unchanged (3'b100 Get, 3'b000 PutFullData) and SHALL NOT check it.
REQ-022 Minimum latency with a_ready_i and d_valid_i both immediate: accept at cycle N, a_valid_o at N+1, d handshake at N+2, resp_valid_o at N+3.
REQ-023 SHALL hold resp_valid_o of the non-owner at 0 at all times, and SHALL hold resp_data_o_p at its last value between responses.
REQ-024 A new request is accepted no earlier than the cycle after resp_valid_o (in IDLE); there is no back-to-back bypass.

Reset
REQ-025 While reset=1 at a clock edge, SHALL enter IDLE; clear a_valid_o, d_ready_o, both req_ready_o, both resp_valid_o and resp_err_o; zero the latched request and both resp_data_o; set the round-robin pointer to favour port 0.
REQ-026 Reset mid-transaction (SEND or WAIT) SHALL abandon the transaction with no response; a later stale d_valid_i SHALL be ignored.
REQ-027 Requests SHALL be accepted starting the first cycle after reset deasserts.

Configuration
REQ-028 SHALL use macro TL_ARB_ROUND_ROBIN_EN to select the arbitration policy.
REQ-029 When TL_ARB_ROUND_ROBIN_EN is defined, on a simultaneous request the port not granted last SHALL win; the pointer updates only on a grant.
REQ-030 When TL_ARB_ROUND_ROBIN_EN is undefined, port 1 (data) SHALL always win ties, and no pointer state SHALL exist.

Verification
REQ-031 Single fetch: port0 Get addr 0x004, a_ready_i=1, D replies opcode 001 data 0x00000013 -> resp_valid_o_0 at N+3 with data 0x00000013, resp_err_o_0=0.
REQ-032 Contention: both valid after reset, round-robin build -> order port0, port1, port0. Fixed build -> port1 is served first while both ports stay asserted.
REQ-033 Backpressure: a_ready_i low 5 cycles -> a_valid_o held, address and data stable for all 5 cycles, single handshake.
REQ-034 Error: D replies opcode 3'b010 -> resp_valid_o_1=1 and resp_err_o_1=1 for one cycle.
REQ-035 Reset asserted in WAIT, then d_valid_i=1 -> no resp_valid_o; next port0 request proceeds normally.
